multicycle_control_fsm: RTL and testbench

//  Multi-cycle MIPS controller; sequences the shared datapath (one memory port, one ALU)

---
 rtl/multicycle_control_fsm.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS controller: sequences a shared memory port and ALU through
// FETCH / DECODE / EXECUTE / MEM / WRITEBACK with a req/ready memory handshake.
// Optional feature: define MEM_TIMEOUT_EN to bound memory waits to TIMEOUT_CYCLES
// cycles, after which the access is abandoned and an exception is raised.
module multicycle_control_fsm
`ifdef MEM_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 16)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_half,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       exception,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_BRANCH   = 4'd5,
    S_JUMP     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_MEM_WB   = 4'd10,
    S_EXC      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t     state_q;
  state_t     state_next;
  logic [5:0] opcode_q;
  logic       timeout_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;

  assign in_wait     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout_hit = in_wait && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: clears on every state entry, counts unanswered request cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state_next != state_q) begin
      wait_cnt <= '0;
    end else if (in_wait && !mem_ready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register and opcode latch (opcode captured only while in DECODE).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= 6'h00;
    end else begin
      state_q <= state_next;
      if (state_q == S_DECODE) begin
        opcode_q <= opcode;
      end
    end
  end

  // Next-state logic; a completed access (mem_ready) takes priority over timeout.
  always_comb begin
    state_next = S_FETCH;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)        state_next = S_DECODE;
        else if (timeout_hit) state_next = S_EXC;
        else                  state_next = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                    state_next = S_EXEC_R;
          OP_J:                        state_next = S_JUMP;
          OP_BEQ, OP_BNE:              state_next = S_BRANCH;
          OP_ADDI:                     state_next = S_EXEC_I;
          OP_LW, OP_LH, OP_SW, OP_SH:  state_next = S_MEM_ADDR;
          default:                     state_next = S_EXC;
        endcase
      end
      S_EXEC_R:   state_next = S_ALU_WB;
      S_EXEC_I:   state_next = S_ALU_WB;
      S_ALU_WB:   state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_MEM_ADDR: state_next = opcode_q[3] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)        state_next = S_MEM_WB;
        else if (timeout_hit) state_next = S_EXC;
        else                  state_next = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ready)        state_next = S_FETCH;
        else if (timeout_hit) state_next = S_EXC;
        else                  state_next = S_MEM_WR;
      end
      S_MEM_WB:   state_next = S_FETCH;
      S_EXC:      state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // Control decode from the state register; everything is forced low during reset.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_half      = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    exception     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = (opcode_q == OP_RTYPE);
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
          branch_ne     = (opcode_q == OP_BNE);
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        S_MEM_RD: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          mem_half = ~opcode_q[1];
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          mem_half = ~opcode_q[1];
          mem_we   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_EXC: begin
          exception = 1'b1;
          pc_write  = 1'b1;
          pc_src    = 2'b11;
        end
        default: begin
        end
      endcase
    end
  end

  assign state = reset ? 4'd0 : 4'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: vector table plus hand-written
// stall / timeout sequences, checked through an expected-value queue.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_we, mem_half, iord, ir_write, pc_write, pc_write_cond, branch_ne;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg, exception;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_half(mem_half), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .exception(exception),
    .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_we, mem_half, iord, ir_write, pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_write, reg_dst, mem_to_reg, exception;
  } outs_t;

  // rst/op/rdy drive the DUT; iop is the instruction in flight; st the expected state.
  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic [5:0] iop;
    logic [3:0] st;
  } vec_t;

  vec_t  vecs[$];
  outs_t sb[$];

  // Expected control word for a state, taken from the controller's output table.
  function automatic outs_t spec_ctl(input logic [3:0] st, input logic [5:0] iop,
                                     input logic rdy, input logic rst);
    outs_t o;
    o = '0;
    if (rst) return o;
    o.st = st;
    case (st)
      4'd0:  begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      4'd1:  o.alu_src_b = 2'b11;
      4'd2:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      4'd3:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4'd4:  begin o.reg_write = 1; o.reg_dst = (iop == 6'h00); end
      4'd5:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_src = 2'b01;
                   o.branch_ne = (iop == 6'h05); end
      4'd6:  begin o.pc_write = 1; o.pc_src = 2'b10; end
      4'd7:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4'd8:  begin o.mem_req = 1; o.iord = 1; o.mem_half = (iop == 6'h21); end
      4'd9:  begin o.mem_req = 1; o.iord = 1; o.mem_we = 1; o.mem_half = (iop == 6'h29); end
      4'd10: begin o.reg_write = 1; o.mem_to_reg = 1; end
      4'd11: begin o.exception = 1; o.pc_write = 1; o.pc_src = 2'b11; end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic row(input logic rst, input logic [5:0] op, input logic rdy,
                     input logic [5:0] iop, input logic [3:0] st);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.iop = iop; v.st = st;
    vecs.push_back(v);
  endtask

  // One clock of stimulus: drive, queue the expectation, sample mid-cycle, compare.
  task automatic apply(input logic rst, input logic [5:0] op, input logic rdy,
                       input logic [5:0] iop, input logic [3:0] st, input string name);
    outs_t got, exp;
    @(negedge clk);
    reset = rst; opcode = op; mem_ready = rdy;
    sb.push_back(spec_ctl(st, iop, rdy, rst));
    #1;
    got = {state, mem_req, mem_we, mem_half, iord, ir_write, pc_write, pc_write_cond,
           branch_ne, pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
           mem_to_reg, exception};
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
               name, got, got.st, exp, exp.st);
    end
  endtask

  initial begin
    // Reset held three cycles, then instruction sequences with mem_ready high.
    repeat (3) row(1, 6'h00, 1, 6'h00, 0);
    row(0, 6'h00, 1, 6'h00, 0); row(0, 6'h00, 1, 6'h00, 1); row(0, 6'h00, 1, 6'h00, 2); row(0, 6'h00, 1, 6'h00, 4);
    // addi; opcode input changes after DECODE and must be ignored
    row(0, 6'h08, 1, 6'h08, 0); row(0, 6'h08, 1, 6'h08, 1); row(0, 6'h3F, 1, 6'h08, 3); row(0, 6'h00, 1, 6'h08, 4);
    row(0, 6'h02, 1, 6'h02, 0); row(0, 6'h02, 1, 6'h02, 1); row(0, 6'h02, 1, 6'h02, 6);
    row(0, 6'h04, 1, 6'h04, 0); row(0, 6'h04, 1, 6'h04, 1); row(0, 6'h04, 1, 6'h04, 5);
    row(0, 6'h05, 1, 6'h05, 0); row(0, 6'h05, 1, 6'h05, 1); row(0, 6'h00, 1, 6'h05, 5);
    // lw with three stalled cycles in MEM_RD
    row(0, 6'h23, 1, 6'h23, 0); row(0, 6'h23, 1, 6'h23, 1); row(0, 6'h23, 1, 6'h23, 7);
    repeat (3) row(0, 6'h23, 0, 6'h23, 8);
    row(0, 6'h23, 1, 6'h23, 8); row(0, 6'h23, 1, 6'h23, 10);
    row(0, 6'h21, 1, 6'h21, 0); row(0, 6'h21, 1, 6'h21, 1); row(0, 6'h21, 1, 6'h21, 7);
    row(0, 6'h21, 1, 6'h21, 8); row(0, 6'h21, 1, 6'h21, 10);
    // sw with two stalled cycles in MEM_WR, then sh
    row(0, 6'h2B, 1, 6'h2B, 0); row(0, 6'h2B, 1, 6'h2B, 1); row(0, 6'h2B, 1, 6'h2B, 7);
    row(0, 6'h2B, 0, 6'h2B, 9); row(0, 6'h2B, 0, 6'h2B, 9); row(0, 6'h2B, 1, 6'h2B, 9);
    row(0, 6'h29, 1, 6'h29, 0); row(0, 6'h29, 1, 6'h29, 1); row(0, 6'h29, 1, 6'h29, 7); row(0, 6'h29, 1, 6'h29, 9);
    // illegal opcodes: lb, sb, 0x3F
    row(0, 6'h20, 1, 6'h20, 0); row(0, 6'h20, 1, 6'h20, 1); row(0, 6'h20, 1, 6'h20, 11);
    row(0, 6'h28, 1, 6'h28, 0); row(0, 6'h28, 1, 6'h28, 1); row(0, 6'h28, 1, 6'h28, 11);
    row(0, 6'h3F, 1, 6'h3F, 0); row(0, 6'h3F, 1, 6'h3F, 1); row(0, 6'h3F, 1, 6'h3F, 11);
    // fetch stall
    row(0, 6'h00, 0, 6'h00, 0); row(0, 6'h00, 0, 6'h00, 0); row(0, 6'h00, 1, 6'h00, 0);
    row(0, 6'h00, 1, 6'h00, 1); row(0, 6'h00, 1, 6'h00, 2); row(0, 6'h00, 1, 6'h00, 4);
    // reset in the middle of a load access
    row(0, 6'h23, 1, 6'h23, 0); row(0, 6'h23, 1, 6'h23, 1); row(0, 6'h23, 1, 6'h23, 7);
    row(0, 6'h23, 0, 6'h23, 8); row(1, 6'h23, 0, 6'h23, 0); row(1, 6'h23, 0, 6'h23, 0);
    row(0, 6'h00, 1, 6'h00, 0); row(0, 6'h00, 1, 6'h00, 1); row(0, 6'h00, 1, 6'h00, 2); row(0, 6'h00, 1, 6'h00, 4);

    foreach (vecs[i])
      apply(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].iop, vecs[i].st, $sformatf("vec%0d", i));

    // Long fetch stall: timeout to EXC after 16 wait cycles, or indefinite wait.
    apply(1, 6'h00, 0, 6'h00, 0, "to_reset");
    for (int k = 0; k < 16; k++) apply(0, 6'h00, 0, 6'h00, 0, $sformatf("fetch_wait%0d", k));
`ifdef MEM_TIMEOUT_EN
    apply(0, 6'h00, 0, 6'h00, 11, "fetch_timeout_exc");
    apply(0, 6'h00, 0, 6'h00, 0, "after_timeout_fetch");
`else
    for (int k = 16; k < 40; k++) apply(0, 6'h00, 0, 6'h00, 0, $sformatf("fetch_wait%0d", k));
`endif

    // Load whose data arrives on the 16th wait cycle: completion wins over timeout.
    apply(0, 6'h23, 1, 6'h23, 0, "rw_fetch");
    apply(0, 6'h23, 1, 6'h23, 1, "rw_decode");
    apply(0, 6'h23, 1, 6'h23, 7, "rw_addr");
    for (int k = 0; k < 15; k++) apply(0, 6'h23, 0, 6'h23, 8, $sformatf("rd_wait%0d", k));
    apply(0, 6'h23, 1, 6'h23, 8, "rd_ready_wins");
    apply(0, 6'h23, 1, 6'h23, 10, "rd_wb");
    apply(0, 6'h00, 1, 6'h00, 0, "rd_back_fetch");

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
